// File: rtl/conv_ctrl.sv
// conv_ctrl: walks every valid output position, issuing K*K X/W read pairs per position,
// driving MAC strobes one cycle behind the reads and handing each result out on valid/ready.
module conv_ctrl #(
   parameter int R = 9,
   parameter int C = 8,
   parameter int MAXK = 4,
   localparam int K_BITS = $clog2(MAXK + 1),
   localparam int X_ADDR_BITS = $clog2(R * C),
   localparam int W_ADDR_BITS = $clog2(MAXK * MAXK),
   localparam int ROW_BITS = $clog2(R),
   localparam int COL_BITS = $clog2(C)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inputs_loaded,
   input  logic [K_BITS-1:0]      K,
   output logic [X_ADDR_BITS-1:0] X_read_addr,
   output logic [W_ADDR_BITS-1:0] W_read_addr,
   output logic                   mac_init,
   output logic                   mac_valid,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ROW_BITS-1:0]    out_row,
   output logic [COL_BITS-1:0]    out_col,
   output logic                   compute_finished
);
   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUTPUT, FINISH} state_t;

   state_t state_q, state_d;
   logic [ROW_BITS-1:0] r_q, r_d;
   logic [COL_BITS-1:0] c_q, c_d;
   logic [K_BITS-1:0] i_q, i_d, j_q, j_d;
   logic mac_valid_q, mac_init_q, fin_q;
   logic [31:0] k_w, r_w, c_w, i_w, j_w;
   logic last_i, last_j, last_r, last_c;

   assign k_w = 32'(K);
   assign r_w = 32'(r_q);
   assign c_w = 32'(c_q);
   assign i_w = 32'(i_q);
   assign j_w = 32'(j_q);
   assign last_j = j_w == k_w - 1;
   assign last_i = i_w == k_w - 1;
   assign last_c = c_w == C - k_w;
   assign last_r = r_w == R - k_w;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         r_q         <= '0;
         c_q         <= '0;
         i_q         <= '0;
         j_q         <= '0;
         mac_valid_q <= 1'b0;
         mac_init_q  <= 1'b0;
         fin_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         c_q         <= c_d;
         i_q         <= i_d;
         j_q         <= j_d;
         mac_valid_q <= state_q == ISSUE;
         mac_init_q  <= state_q == ISSUE && i_q == '0 && j_q == '0;
         fin_q       <= state_q == FINISH;
      end
   end

   // fin_q blocks a restart while input_mems is still lowering inputs_loaded after a finish.
   // The last pair keeps i/j in place so the addresses stay held through DRAIN and OUTPUT.
   always_comb begin
      state_d = state_q;
      r_d = r_q;
      c_d = c_q;
      i_d = i_q;
      j_d = j_q;
      case (state_q)
         IDLE: if (inputs_loaded && !fin_q) begin
            state_d = (K == '0) ? FINISH : ISSUE;
            r_d = '0;
            c_d = '0;
            i_d = '0;
            j_d = '0;
         end
         ISSUE: if (last_i && last_j) state_d = DRAIN;
         else begin
            j_d = last_j ? '0 : j_q + 1'b1;
            i_d = last_j ? i_q + 1'b1 : i_q;
         end
         DRAIN: state_d = OUTPUT;
         OUTPUT: if (out_ready) begin
            state_d = (last_r && last_c) ? FINISH : ISSUE;
            i_d = '0;
            j_d = '0;
            c_d = last_c ? '0 : c_q + 1'b1;
            r_d = (last_r && last_c) ? '0 : last_c ? r_q + 1'b1 : r_q;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid = state_q == OUTPUT;
      compute_finished = state_q == FINISH;
      mac_valid = mac_valid_q;
      mac_init = mac_init_q;
      out_row = r_q;
      out_col = c_q;
      X_read_addr = (state_q == IDLE) ? '0 : X_ADDR_BITS'((r_w + i_w) * C + c_w + j_w);
      W_read_addr = (state_q == IDLE) ? '0 : W_ADDR_BITS'(i_w * k_w + j_w);
   end
endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: stimulus queues the expected output positions per job; a negedge monitor
// checks read addresses, MAC strobes, latency, stall hold and handshakes against that queue.
module tb_conv_ctrl;
   localparam int R = 9, C = 8, MAXK = 4;
   logic clk = 0, reset = 1, inputs_loaded = 0, out_ready = 1;
   logic [2:0] K = '0;
   logic [6:0] X_read_addr;
   logic [3:0] W_read_addr;
   logic mac_init, mac_valid, out_valid, compute_finished;
   logic [3:0] out_row;
   logic [2:0] out_col;
   int tests = 0, fails = 0, hs_cnt = 0;
   typedef struct {int r; int c; int k;} exp_t;
   exp_t q[$];
   int xlog[$], wlog[$];

   always #5 clk = ~clk;

   conv_ctrl #(.R(R), .C(C), .MAXK(MAXK)) dut (
      .clk(clk), .reset(reset), .inputs_loaded(inputs_loaded), .K(K),
      .X_read_addr(X_read_addr), .W_read_addr(W_read_addr),
      .mac_init(mac_init), .mac_valid(mac_valid), .out_valid(out_valid),
      .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
      .compute_finished(compute_finished)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // monitor: px/pw hold the address presented in the previous cycle, which is what a mac_valid refers to
   int cyc = 0, n = 0, t_init = 0, t_hs = 0, px = 0, pw = 0, prow = 0, pcol = 0;
   bit have_hs = 0, stall = 0, prev_cf = 0;
   always @(negedge clk) begin : mon
      exp_t e;
      cyc++;
      if (reset) begin
         n = 0;
         have_hs = 0;
         stall = 0;
         prev_cf = 0;
      end else begin
         if (q.size() > 0) e = q[0];
         if (mac_valid) begin
            if (q.size() == 0) check("mac_unexpected", 1, 0);
            else begin
               check("mac_x", px, (e.r + n / e.k) * C + e.c + n % e.k);
               check("mac_w", pw, n);
               check("mac_init", int'(mac_init), int'(n == 0));
               if (mac_init) begin
                  t_init = cyc;
                  if (have_hs) check("issue_gap", cyc - t_hs, 2);
               end
               xlog.push_back(px);
               wlog.push_back(pw);
               n++;
            end
         end
         if (out_valid) begin
            check("out_mac_overlap", int'(mac_valid), 0);
            if (!stall && q.size() > 0) begin
               check("latency", cyc - t_init, e.k * e.k);
               check("mac_count", n, e.k * e.k);
            end else if (stall) begin
               check("hold_row", int'(out_row), prow);
               check("hold_col", int'(out_col), pcol);
               check("hold_x", int'(X_read_addr), px);
               check("hold_w", int'(W_read_addr), pw);
            end
            if (out_ready) begin
               if (q.size() == 0) check("out_unexpected", 1, 0);
               else begin
                  check("out_row", int'(out_row), e.r);
                  check("out_col", int'(out_col), e.c);
                  void'(q.pop_front());
               end
               n = 0;
               t_hs = cyc;
               have_hs = 1;
               hs_cnt++;
            end
         end
         stall = out_valid && !out_ready;
         if (compute_finished) begin
            check("fin_pending", q.size(), 0);
            check("fin_width", int'(prev_cf), 0);
            if (have_hs) check("fin_after_hs", cyc - t_hs, 1);
            have_hs = 0;
         end
         prev_cf = compute_finished;
      end
      prow = int'(out_row);
      pcol = int'(out_col);
      px = int'(X_read_addr);
      pw = int'(W_read_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_job(input int k);
      if (k > 0)
         for (int r = 0; r <= R - k; r++)
            for (int c = 0; c <= C - k; c++) q.push_back('{r, c, k});
   endtask

   task automatic run_job(input int k, input int stall_cycles, input int exp_outs);
      int t, hs0;
      hs0 = hs_cnt;
      push_job(k);
      K = 3'(k);
      if (stall_cycles > 0) out_ready = 0;
      inputs_loaded = 1;
      if (stall_cycles > 0) begin
         t = 0;
         while (!out_valid && t < 200) begin tick(); t++; end
         check("stall_reach", int'(out_valid), 1);
         repeat (stall_cycles) tick();
         out_ready = 1;
      end
      t = 0;
      while (!compute_finished && t < 5000) begin tick(); t++; end
      check("finish_seen", int'(compute_finished), 1);
      tick();
      tick();
      inputs_loaded = 0;
      tick();
      check("no_restart", int'(mac_valid || out_valid || compute_finished), 0);
      check("out_count", hs_cnt - hs0, exp_outs);
   endtask

   initial begin
      int xs, t;
      int k2x[4] = '{0, 1, 8, 9};
      repeat (3) tick();
      check("reset_outs", int'({X_read_addr, W_read_addr, out_row, out_col,
                                mac_init, mac_valid, out_valid, compute_finished}), 0);
      reset = 0;
      tick();
      // K=2, always ready
      xs = xlog.size();
      run_job(2, 0, 56);
      for (int m = 0; m < 4; m++) begin
         check("k2_first_x", xlog[xs + m], k2x[m]);
         check("k2_first_w", wlog[xs + m], m);
      end
      // K=4, always ready
      xs = xlog.size();
      run_job(4, 0, 30);
      check("k4_mac_total", xlog.size() - xs, 480);
      check("k4_last_first_x", xlog[xs + 464], 44);
      check("k4_last_x", xlog[xs + 479], 71);
      check("k4_last_w", wlog[xs + 479], 15);
      // K=2 with a 10-cycle stall at the first output
      run_job(2, 10, 56);
      // K=0: straight to the finish pulse
      K = '0;
      inputs_loaded = 1;
      tick();
      check("k0_fin_hi", int'(compute_finished), 1);
      inputs_loaded = 0;
      tick();
      check("k0_fin_lo", int'(compute_finished), 0);
      tick();
      check("k0_idle", int'(mac_valid || out_valid || compute_finished), 0);
      // reset in the middle of issuing output (2,3)
      push_job(2);
      K = 3'd2;
      inputs_loaded = 1;
      t = 0;
      while (!(out_row == 4'd2 && out_col == 3'd3 && mac_valid && !out_valid) && t < 2000) begin
         tick();
         t++;
      end
      check("reached_2_3", int'(out_row == 4'd2 && out_col == 3'd3 && !out_valid), 1);
      reset = 1;
      inputs_loaded = 0;
      q.delete();
      tick();
      check("midreset_outs", int'({X_read_addr, W_read_addr, out_row, out_col,
                                   mac_init, mac_valid, out_valid, compute_finished}), 0);
      reset = 0;
      tick();
      // back-to-back jobs: K=3 then K=1
      xs = xlog.size();
      run_job(3, 0, 42);
      check("k3_restart_x", xlog[xs], 0);
      xs = xlog.size();
      run_job(1, 0, 72);
      check("k1_mac_total", xlog.size() - xs, 72);
      for (int m = 0; m < 72; m++) check("k1_x_order", xlog[xs + m], m);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/conv_ctrl.md
Name: conv_ctrl

Overview:
- Sequencer for the convolution datapath, sitting between input_mems and the MAC/output stage.
- Once input_mems reports inputs_loaded, it walks every valid output position of the (R-K+1) x (C-K+1) output matrix.
- For each position it issues K*K X/W read-address pairs, drives MAC init/valid strobes aligned to the 1-cycle memory read latency, and presents each finished result on a valid/ready handshake.
- After the last result is accepted it pulses compute_finished so input_mems returns to loading.

Parameters:
- R, 9, rows of X matrix
- C, 8, columns of X matrix
- MAXK, 4, maximum kernel size; must satisfy MAXK <= min(R,C)
- K_BITS, $clog2(MAXK+1), localparam, width of K
- X_ADDR_BITS, $clog2(R*C), localparam
- W_ADDR_BITS, $clog2(MAXK*MAXK), localparam

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inputs_loaded  in  1  from input_mems; memories hold a complete job
- K  in  K_BITS  kernel size from input_mems; stable while inputs_loaded=1
- X_read_addr  out  X_ADDR_BITS  X memory read address
- W_read_addr  out  W_ADDR_BITS  W memory read address
- mac_init  out  1  first product of current output; accumulator loads instead of adding
- mac_valid  out  1  X_data/W_data product is valid this cycle
- out_valid  out  1  accumulator holds a finished output element
- out_ready  in  1  downstream accepts output element
- out_row  out  $clog2(R)  row index of current output element
- out_col  out  $clog2(C)  column index of current output element
- compute_finished  out  1  one-cycle pulse after last output accepted

Behaviour:
- Reset: state IDLE; all counters 0; X_read_addr, W_read_addr, out_row, out_col = 0; mac_init, mac_valid, out_valid, compute_finished = 0. The mac strobe pipeline register is also cleared. Reset mid-job abandons the job immediately; no compute_finished pulse.
- Counters: r in 0..R-K, c in 0..C-K, i and j in 0..K-1.
  - X_read_addr = (r+i)*C + (c+j).
  - W_read_addr = i*K + j.
  - Computed at full width, truncated to the port width. With K <= MAXK <= min(R,C), truncation never loses bits.
- IDLE:
  - Addresses 0.
  - If inputs_loaded=1 and K=0: go to FINISH, with no outputs produced.
  - If inputs_loaded=1 and K>=1: clear i, j, r, c and go to ISSUE.
- ISSUE:
  - One address pair per cycle, j fastest, then i.
  - The pair for (i,j)=(K-1,K-1) is the last; it is followed by DRAIN.
  - Issue never stalls; out_ready has no effect here.
- Strobe pipeline (registered, 1 cycle after issue):
  - mac_valid=1 in the cycle after each ISSUE cycle.
  - mac_init=1 together with the mac_valid of pair (0,0) only.
  - With ISSUE starting at cycle t0, mac_valid is high at t0+1..t0+K*K.
- DRAIN: one cycle, in which the last mac_valid is active. Next state OUTPUT.
- OUTPUT:
  - out_valid=1, with out_row=r, out_col=c held stable until out_valid && out_ready.
  - First out_valid is at t0+K*K+1. Addresses are held, and mac_valid=0 throughout.
  - On handshake: advance c; on wrap of c, advance r.
  - If (r,c) was (R-K, C-K), go to FINISH. Otherwise clear i,j and go to ISSUE next cycle.
  - No new issue may start until the handshake completes; results are never overlapped.
- FINISH: compute_finished=1 for exactly one cycle, then IDLE.
  - input_mems drops inputs_loaded the following cycle, so no spurious restart.
- inputs_loaded falling outside IDLE is a contract violation; it is ignored and the job continues.
- K=1: per output, 1 issue cycle, 1 DRAIN cycle, then OUTPUT; mac_init and mac_valid coincide.
- Per-output latency from ISSUE entry to out_valid: K*K+1 cycles, plus any cycles with out_ready low.

Test Plan:
- R=9, C=8, K=2, out_ready=1:
  - First four address pairs: X 0,1,8,9 with W 0,1,2,3.
  - mac_init on the first mac_valid only; out_valid 5 cycles after ISSUE entry.
  - Exactly 56 outputs (8x7), then one compute_finished pulse.
- K=4, out_ready=1:
  - 30 outputs.
  - Last output (5,4) first X address 44, last X address 71, last W address 15.
  - compute_finished one cycle after final handshake.
- K=2, out_ready held low 10 cycles at the first OUTPUT:
  - out_valid, out_row=0, out_col=0 and addresses stay stable.
  - mac_valid=0 throughout; next ISSUE starts the cycle after out_ready rises.
- K=0 with inputs_loaded=1: no mac_valid or out_valid; compute_finished high exactly one cycle after leaving IDLE.
- Reset asserted mid-ISSUE of output (2,3):
  - Next cycle all outputs are 0 and the state is IDLE.
  - A new job with K=3 restarts at (0,0) with X address 0.
- Two back-to-back jobs (K=3 then K=1):
  - No restart while inputs_loaded is still high the cycle after compute_finished.
  - Second job produces 72 outputs with X addresses 0..71 in order.
